// File: rtl/rr_grant_arbiter.sv
// Round-robin grant arbiter: rotated LSB-first one-hot select, registered grant held per transaction.
// Optional ARB_MAX_HOLD_EN adds a hold counter that preempts an unlocked owner after MAX_HOLD cycles.
module rr_grant_arbiter #(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 16,
    localparam int W_IDX   = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] lock,
    output logic [N_REQ-1:0] gnt,
    output logic             gnt_valid,
    output logic [W_IDX-1:0] gnt_idx,
    output logic             handover
);

    typedef enum logic {IDLE, GRANT} state_e;

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [W_IDX-1:0]   ptr_q, ptr_d;
    logic [W_IDX-1:0]   idx_q, idx_d;
    logic               valid_q, valid_d;
    logic               ho_q, ho_d;

    logic [W_IDX-1:0]   shift;
    logic [2*N_REQ-1:0] rot2, pick2;
    logic [N_REQ-1:0]   rot, pick_rot, pick;
    logic [W_IDX-1:0]   pick_idx;
    logic               owner_req, others, preempt, new_grant;

    // Rotate so (ptr+1) lands at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        shift    = (ptr_q == W_IDX'(N_REQ - 1)) ? '0 : ptr_q + 1'b1;
        rot2     = {req, req} >> shift;
        rot      = rot2[N_REQ-1:0];
        pick_rot = rot & (~rot + 1'b1);
        pick2    = {pick_rot, pick_rot} << shift;
        pick     = pick2[2*N_REQ-1:N_REQ];
        pick_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick[i]) pick_idx = W_IDX'(i);
        end
    end

    assign owner_req = |(req & gnt_q);
    assign others    = |(req & ~gnt_q);

`ifdef ARB_MAX_HOLD_EN
    localparam int CW = $clog2(MAX_HOLD) + 1;
    logic [CW-1:0] cnt_q, cnt_d;

    assign preempt = (state_q == GRANT) && (cnt_q == CW'(MAX_HOLD - 1))
                     && others && !(|(lock & gnt_q));

    // Saturates at the preemption threshold so a lone owner keeps the grant.
    always_comb begin
        cnt_d = cnt_q;
        if (new_grant)
            cnt_d = '0;
        else if (state_q == GRANT && cnt_q != CW'(MAX_HOLD - 1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    logic unused_cfg;
    assign preempt    = 1'b0;
    assign unused_cfg = ^{lock, MAX_HOLD[0]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= W_IDX'(N_REQ - 1);
            idx_q   <= '0;
            valid_q <= 1'b0;
            ho_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            ho_q    <= ho_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        new_grant = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) new_grant = 1'b1;
            end
            GRANT: begin
                if (owner_req && !preempt) begin
                    gnt_d = gnt_q;
                end else if (others) begin
                    // Owner sits at ptr, so it is last in line when preempted.
                    new_grant = 1'b1;
                end else begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
        if (new_grant) begin
            state_d = GRANT;
            gnt_d   = pick;
            ptr_d   = pick_idx;
        end
    end

    always_comb begin
        valid_d = |gnt_d;
        idx_d   = (state_d == GRANT) ? ptr_d : '0;
        ho_d    = new_grant;
    end

    assign gnt       = gnt_q;
    assign gnt_valid = valid_q;
    assign gnt_idx   = idx_q;
    assign handover  = ho_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Self-checking bench for rr_grant_arbiter: vector table, hand sequences, random invariant sweep.
module tb_rr_grant_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] lock = '0;
    logic [N-1:0] gnt;
    logic         gnt_valid;
    logic [1:0]   gnt_idx;
    logic         handover;

    rr_grant_arbiter #(.N_REQ(N), .MAX_HOLD(4)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock),
        .gnt(gnt), .gnt_valid(gnt_valid), .gnt_idx(gnt_idx), .handover(handover)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] req;
        logic [N-1:0] lock;
        logic [N-1:0] gnt;
        logic         ho;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];
    int   n_chk = 0;
    int   n_pass = 0;
    int   wait_cnt[N];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic add(input logic [N-1:0] r, input logic [N-1:0] l,
                       input logic [N-1:0] g, input logic h);
        vec_t v;
        v.req = r; v.lock = l; v.gnt = g; v.ho = h;
        tbl.push_back(v);
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] l,
                        input logic [N-1:0] g, input logic h, input string name);
        vec_t e;
        logic [1:0] ei;
        @(negedge clk);
        req = r; lock = l;
        e.req = r; e.lock = l; e.gnt = g; e.ho = h;
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        ei = '0;
        for (int i = 0; i < N; i++) if (e.gnt[i]) ei = 2'(i);
        chk({name, " gnt"}, 32'(gnt), 32'(e.gnt));
        chk({name, " valid"}, 32'(gnt_valid), 32'(|e.gnt));
        chk({name, " idx"}, 32'(gnt_idx), 32'(ei));
        chk({name, " handover"}, 32'(handover), 32'(e.ho));
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; lock = '0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
    endtask

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] gp;
        do_reset();
        chk("reset gnt", 32'(gnt), 0);
        chk("reset valid", 32'(gnt_valid), 0);
        chk("reset handover", 32'(handover), 0);

        for (int k = 0; k < 5; k++) add(4'b0000, 4'b0000, 4'b0000, 1'b0);
        // Each owner holds two cycles, drops for one; switches are gap-free.
        add(4'b1111, 4'b0000, 4'b0001, 1'b1);
        add(4'b1111, 4'b0000, 4'b0001, 1'b0);
        add(4'b1110, 4'b0000, 4'b0010, 1'b1);
        add(4'b1111, 4'b0000, 4'b0010, 1'b0);
        add(4'b1101, 4'b0000, 4'b0100, 1'b1);
        add(4'b1111, 4'b0000, 4'b0100, 1'b0);
        add(4'b1011, 4'b0000, 4'b1000, 1'b1);
        add(4'b1111, 4'b0000, 4'b1000, 1'b0);
        add(4'b0111, 4'b0000, 4'b0001, 1'b1);
        add(4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(4'b0101, 4'b0000, 4'b0100, 1'b1);
        add(4'b0001, 4'b0000, 4'b0001, 1'b1);
        add(4'b0000, 4'b0000, 4'b0000, 1'b0);
        add(4'b0001, 4'b0000, 4'b0001, 1'b1);
        add(4'b1110, 4'b0000, 4'b0010, 1'b1);
        add(4'b1110, 4'b0010, 4'b0010, 1'b0);
        add(4'b0000, 4'b1111, 4'b0000, 1'b0);
        add(4'b0000, 4'b1111, 4'b0000, 1'b0);
        for (int k = 0; k < tbl.size(); k++)
            step(tbl[k].req, tbl[k].lock, tbl[k].gnt, tbl[k].ho, $sformatf("vec%0d", k));

        do_reset();
`ifdef ARB_MAX_HOLD_EN
        step(4'b0011, 4'b0000, 4'b0001, 1'b1, "hold0 first");
        for (int k = 0; k < 3; k++) step(4'b0011, 4'b0000, 4'b0001, 1'b0, "hold0");
        step(4'b0011, 4'b0000, 4'b0010, 1'b1, "preempt to 1");
        for (int k = 0; k < 3; k++) step(4'b0011, 4'b0000, 4'b0010, 1'b0, "hold1");
        step(4'b0011, 4'b0000, 4'b0001, 1'b1, "preempt back to 0");
        do_reset();
`endif
        step(4'b0011, 4'b0001, 4'b0001, 1'b1, "locked first");
        for (int k = 0; k < 8; k++) step(4'b0011, 4'b0001, 4'b0001, 1'b0, "locked hold");

        // Asynchronous reset between edges while a grant is live.
        do_reset();
        step(4'b0100, 4'b0000, 4'b0100, 1'b1, "pre-reset grant");
        #2 rst_n = 1'b0;
        #1;
        chk("async rst gnt", 32'(gnt), 0);
        chk("async rst valid", 32'(gnt_valid), 0);
        chk("async rst idx", 32'(gnt_idx), 0);
        chk("async rst handover", 32'(handover), 0);
        @(negedge clk); rst_n = 1'b1;
        step(4'b1000, 4'b0000, 4'b1000, 1'b1, "post-reset grant");
        step(4'b1000, 4'b0000, 4'b1000, 1'b0, "post-reset hold");

        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        r = '0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) if ($urandom_range(3) == 0) r[i] = ~r[i];
            req = r;
            lock = N'($urandom_range(15));
            @(posedge clk); #1;
            gp = gnt;
            chk("rand onehot", 32'((gp & (gp - 1'b1)) == '0), 1);
            chk("rand gnt within req", 32'(gp & ~r), 0);
            chk("rand valid", 32'(gnt_valid), 32'(|gp));
            for (int i = 0; i < N; i++) begin
                if (!r[i] || gp[i]) wait_cnt[i] = 0;
                else if (handover) wait_cnt[i]++;
            end
            chk("rand starvation", 32'((wait_cnt[0] <= N) && (wait_cnt[1] <= N)
                                       && (wait_cnt[2] <= N) && (wait_cnt[3] <= N)), 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rr_grant_arbiter.md
Name: rr_grant_arbiter

Overview:
- Round-robin arbiter sharing one downstream resource (bus port, SRAM port, or shared peripheral) between N_REQ requesters.
- Uses a one-hot least-significant-set-bit priority select, rotated by a registered last-owner pointer.
- Grant is registered and held for the owner's whole transaction (req high), then handed directly to the next requester.
- Sits between the master-side request logic and the resource mux; gnt drives the mux select.

Parameters:
- N_REQ, 4, number of requesters (≥2).
- MAX_HOLD, 16, cycles an owner keeps the grant before preemption; used only with ARB_MAX_HOLD_EN; ≥2.
- W_IDX, derived localparam = max(1, clog2(N_REQ)), width of gnt_idx.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N_REQ  per-requester request level; held high for the duration of the transaction.
- lock  input  N_REQ  per-requester lock; while the owner's bit is high, the owner is never preempted.
- gnt  output  N_REQ  registered one-hot grant; all zero when idle.
- gnt_valid  output  1  registered; equals |gnt.
- gnt_idx  output  W_IDX  registered binary index of the owner; 0 when idle.
- handover  output  1  one-cycle pulse, registered; high in the first cycle of any new grant.

Behaviour:
- Reset (async, immediate):
  - gnt=0, gnt_valid=0, gnt_idx=0, handover=0.
  - Last-owner pointer = N_REQ-1, so requester 0 has top priority first.
  - Hold counter = 0.
- State machine:
  - IDLE (gnt=0): any req high → GRANT next edge; requester chosen by round-robin.
  - GRANT (owner o):
    - req[o] high → stay, gnt unchanged.
    - req[o] low, others pending → re-arbitrate; new owner's gnt is high at the next edge (direct A→B switch, no idle gap).
    - req[o] low, none pending → IDLE.
- Round-robin: candidate order is (ptr+1) mod N_REQ upward with wrap, where ptr = last owner. Implement as a rotate of req, then LSB one-hot select, then rotate back. Update ptr to the new owner on every grant.
- Latency: req rising at edge t on an idle arbiter → gnt high after edge t+1 (1 cycle). Release at t → next grant after t+1.
- handover: high for the first cycle of each grant, including direct switches. Also high if the same requester regains the grant after an idle cycle.
- Simultaneous req rise from several requesters in IDLE: exactly one grant, closest after ptr.
- Owner drops req while others rise in the same cycle: re-arbitrate over the current req vector. The dropping owner has lowest priority because ptr = owner.
- gnt is always one-hot or zero. Never grant a requester whose req is low in the arbitration cycle.
- Reset asserted mid-grant: gnt drops asynchronously. After release, state is IDLE with ptr = N_REQ-1.
- lock with req low: ignored; lock never creates a grant.

Optional Feature:
- Macro: ARB_MAX_HOLD_EN.
- Defined:
  - Hold counter, clog2(MAX_HOLD)+1 bits, increments each GRANT cycle and clears on every new grant.
  - When the counter reaches MAX_HOLD-1, another req is pending, and lock[owner] is low: preempt. Next edge grants the next round-robin requester; handover pulses.
  - A preempted owner keeping req high re-enters normal rotation.
  - With no other requester pending, the counter saturates and the owner keeps the grant.
- Undefined: no counter; the owner holds until it drops req, regardless of lock.

Test Plan (N_REQ=4, MAX_HOLD=4):
- Reset, then req=4'b0000 for 5 cycles → gnt=0, gnt_valid=0, handover=0 throughout.
- req=4'b1111 held, each owner drops req for 1 cycle after 2 granted cycles then reasserts → grant order 0,1,2,3,0 with gnt_idx matching; handover pulse at each switch; no idle cycle between owners.
- req=4'b0101, ptr=0 → gnt=4'b0100. Drop req[2] → gnt=4'b0001 next cycle.
- ARB_MAX_HOLD_EN defined, req=4'b0011, no lock → owner 0 for 4 cycles, then gnt=4'b0010. Repeat with lock[0]=1 → gnt stays 4'b0001 indefinitely.
- Assert rst_n=0 mid-grant between clock edges → gnt=0 immediately. After release with req=4'b1000 → gnt=4'b1000 one cycle later.
- Random req/lock for 10k cycles → assertions: gnt one-hot-or-zero; gnt & ~req_prev == 0; no requester starves beyond N_REQ grants while its req is held.
